// File: rtl/scandoubler_linebuf.sv
// ============================================================================
// Module   : scandoubler_linebuf
// Purpose  : 15 kHz -> 31 kHz scandoubler; ping-pong line buffer, each stored
//            line is read back twice at the doubled pixel rate.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module scandoubler_linebuf #(
    parameter int ADDR_W  = 10,
    parameter int HSYNC_W = 64
) (
    input  logic              clk_peripheral,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              ce_pix2,
    input  logic [8:0]        video_15,
    input  logic              hsync_15,
    input  logic              vsync_15,
    output logic [8:0]        video_31,
    output logic              hsync_31,
    output logic              vsync_31,
    output logic [ADDR_W-1:0] line_len,
    output logic              overflow
);

    localparam int              c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_addr_max = '1;
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    // Both banks share one array; the bank select is the address MSB.
    logic [8:0]        r_mem [0:2*c_depth-1];

    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [1:0]        r_valid_cnt;
    logic              r_hsync_prev;
    logic              r_vsync_smp;

    logic              w_edge;
    logic              w_wr_bank;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_valid;
    logic              w_rd_wrap;
    logic              w_hs_active;

    always_comb begin
        w_edge      = ce_pix & r_hsync_prev & ~hsync_15;
        w_wr_bank   = w_edge ? ~r_wr_bank : r_wr_bank;
        w_wr_addr   = w_edge ? '0 : r_wr_addr;
        w_valid     = (r_valid_cnt == 2'd2);
        w_rd_wrap   = (line_len == '0) || (r_rd_addr == (line_len - c_addr_one));
        w_hs_active = (32'(r_rd_addr) < HSYNC_W);
    end

    always_ff @(posedge clk_peripheral) begin
        if (ce_pix) begin
            r_mem[{w_wr_bank, w_wr_addr}] <= video_15;
        end
    end

    always_ff @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) begin
            video_31     <= '0;
            hsync_31     <= 1'b1;
            vsync_31     <= 1'b1;
            line_len     <= '0;
            overflow     <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_valid_cnt  <= 2'd0;
            // Cleared so a reset released inside an hsync pulse is not a line edge.
            r_hsync_prev <= 1'b0;
            r_vsync_smp  <= 1'b1;
        end else begin
            if (ce_pix) begin
                r_hsync_prev <= hsync_15;
                r_vsync_smp  <= vsync_15;
            end

            if (w_edge) begin
                line_len  <= r_wr_addr;
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
                r_wr_addr <= c_addr_one;
                r_rd_addr <= '0;
                if (r_valid_cnt != 2'd2) begin
                    r_valid_cnt <= r_valid_cnt + 2'd1;
                end
            end else begin
                if (ce_pix) begin
                    if (r_wr_addr == c_addr_max) begin
                        overflow <= 1'b1;
                    end else begin
                        r_wr_addr <= r_wr_addr + c_addr_one;
                    end
                end

                if (ce_pix2) begin
                    r_rd_addr <= w_rd_wrap ? '0 : (r_rd_addr + c_addr_one);
                    if (w_valid) begin
                        video_31 <= r_mem[{r_rd_bank, r_rd_addr}];
                        hsync_31 <= ~w_hs_active;
                        if (r_rd_addr == '0) begin
                            vsync_31 <= r_vsync_smp;
                        end
                    end else begin
                        video_31 <= '0;
                        hsync_31 <= 1'b1;
                        vsync_31 <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scandoubler_linebuf.sv
// ============================================================================
// Module   : tb_scandoubler_linebuf
// Purpose  : Self-checking bench for scandoubler_linebuf against a line-level model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_scandoubler_linebuf;

    localparam int ADDR_W  = 10;
    localparam int HSYNC_W = 64;
    localparam int MAXL    = (1 << ADDR_W) - 1;

    logic              clk_peripheral = 1'b0;
    logic              reset_n        = 1'b0;
    logic              ce_pix         = 1'b0;
    logic              ce_pix2        = 1'b0;
    logic [8:0]        video_15       = '0;
    logic              hsync_15       = 1'b1;
    logic              vsync_15       = 1'b1;
    logic [8:0]        video_31;
    logic              hsync_31;
    logic              vsync_31;
    logic [ADDR_W-1:0] line_len;
    logic              overflow;

    scandoubler_linebuf #(.ADDR_W(ADDR_W), .HSYNC_W(HSYNC_W)) dut (
        .clk_peripheral (clk_peripheral),
        .reset_n        (reset_n),
        .ce_pix         (ce_pix),
        .ce_pix2        (ce_pix2),
        .video_15       (video_15),
        .hsync_15       (hsync_15),
        .vsync_15       (vsync_15),
        .video_31       (video_31),
        .hsync_31       (hsync_31),
        .vsync_31       (vsync_31),
        .line_len       (line_len),
        .overflow       (overflow)
    );

    always #5 clk_peripheral = ~clk_peripheral;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;
    logic vs_lvl = 1'b1;

    // Line-level reference: a line being collected, the last completed line,
    // and a read position that walks the completed line cyclically.
    logic [8:0] m_cur  [0:MAXL-1];
    logic [8:0] m_done [0:MAXL-1];
    int   m_cur_n, m_len, m_pos, m_edges;
    bit   m_prev_hs, m_vs, m_ovf, m_is_edge;
    logic [8:0] e_video;
    bit   e_hs, e_vs;

    always @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) begin
            m_cur_n = 0; m_len = 0; m_pos = 0; m_edges = 0;
            m_prev_hs = 1'b0; m_vs = 1'b1; m_ovf = 1'b0;
            e_video = '0; e_hs = 1'b1; e_vs = 1'b1;
        end else begin
            m_is_edge = ce_pix && m_prev_hs && !hsync_15;
            if (m_is_edge) begin
                for (int i = 0; i < m_cur_n; i++) m_done[i] = m_cur[i];
                m_len   = m_cur_n;
                m_cur_n = 0;
                m_pos   = 0;
                if (m_edges < 2) m_edges++;
            end
            if (ce_pix) begin
                if (m_cur_n < MAXL) begin
                    m_cur[m_cur_n] = video_15;
                    m_cur_n++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (ce_pix2 && !m_is_edge) begin
                if (m_edges == 2) begin
                    e_video = m_done[m_pos];
                    e_hs    = (m_pos >= HSYNC_W);
                    if (m_pos == 0) e_vs = m_vs;
                end else begin
                    e_video = '0; e_hs = 1'b1; e_vs = 1'b1;
                end
                m_pos = (m_len == 0) ? 0 : (m_pos + 1) % m_len;
            end
            if (ce_pix) begin
                m_prev_hs = hsync_15;
                m_vs      = vsync_15;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp();
        if (chk_en) begin
            checks++;
            if (video_31 !== e_video || hsync_31 !== e_hs || vsync_31 !== e_vs ||
                line_len !== ADDR_W'(m_len) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL model t=%0t: video=%h/%h hs=%b/%b vs=%b/%b len=%0d/%0d ovf=%b/%b (got/expected)",
                         $time, video_31, e_video, hsync_31, e_hs, vsync_31, e_vs,
                         line_len, m_len, overflow, m_ovf);
            end
        end
    endtask

    // One input pixel = 4 clocks: ce_pix+ce_pix2, idle, ce_pix2, idle.
    task automatic pixel(input logic [8:0] v, input logic hs, input logic vs);
        @(negedge clk_peripheral); cmp();
        video_15 = v; hsync_15 = hs; vsync_15 = vs; ce_pix = 1'b1; ce_pix2 = 1'b1;
        @(negedge clk_peripheral); cmp();
        ce_pix = 1'b0; ce_pix2 = 1'b0;
        @(negedge clk_peripheral); cmp();
        ce_pix2 = 1'b1;
        @(negedge clk_peripheral); cmp();
        ce_pix2 = 1'b0;
    endtask

    task automatic run_line(input int len, input int hsw, input bit rnd,
                            input int vs_at, input logic vs_new);
        for (int p = 0; p < len; p++) begin
            if (p == vs_at) vs_lvl = vs_new;
            pixel(rnd ? 9'($urandom) : 9'(p % 512), (p < hsw) ? 1'b0 : 1'b1, vs_lvl);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_peripheral); reset_n = 1'b0;
        @(negedge clk_peripheral);
        @(negedge clk_peripheral); reset_n = 1'b1;
        for (int k = 0; k < 4; k++) pixel(9'd0, 1'b1, vs_lvl);
    endtask

    typedef struct {
        bit do_rst;
        int len;
        int hsw;
        int n_lines;
        int exp_len;
        bit exp_ovf;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b1,  448, 32, 3,  448, 1'b0};
        vecs[1] = '{1'b1,   32,  8, 4,   32, 1'b0};
        vecs[2] = '{1'b0, 1100, 32, 2, 1023, 1'b1};
        vecs[3] = '{1'b0,  448, 32, 2,  448, 1'b1};
        vecs[4] = '{1'b1,  448, 32, 2,  448, 1'b0};

        repeat (3) @(negedge clk_peripheral);
        chk_en = 1'b1;
        check("rst_video", video_31, 9'd0);
        check("rst_hsync", hsync_31, 1'b1);
        check("rst_vsync", vsync_31, 1'b1);
        check("rst_len",   line_len, '0);
        check("rst_ovf",   overflow, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) pixel(9'd0, 1'b1, vs_lvl);

        // Asynchronous reset in the middle of a valid line with strobes active.
        for (int l = 0; l < 3; l++) run_line(100, 10, 1'b0, -1, 1'b1);
        for (int p = 0; p < 50; p++) pixel(9'(p), (p < 10) ? 1'b0 : 1'b1, vs_lvl);
        @(negedge clk_peripheral); cmp();
        video_15 = 9'h155; hsync_15 = 1'b1; ce_pix = 1'b1; ce_pix2 = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("arst_video", video_31, 9'd0);
        check("arst_hsync", hsync_31, 1'b1);
        check("arst_vsync", vsync_31, 1'b1);
        check("arst_len",   line_len, '0);
        check("arst_ovf",   overflow, 1'b0);
        @(negedge clk_peripheral); cmp();
        ce_pix = 1'b0; ce_pix2 = 1'b0;
        @(negedge clk_peripheral); cmp();
        reset_n = 1'b1;
        for (int p = 0; p < 50; p++) pixel(9'(p + 1), 1'b1, vs_lvl);
        check("post_rst_video", video_31, 9'd0);
        run_line(100, 10, 1'b0, -1, 1'b1);
        check("one_edge_video", video_31, 9'd0);
        check("one_edge_hsync", hsync_31, 1'b1);
        run_line(100, 10, 1'b0, -1, 1'b1);

        // Line-length / overflow table.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_rst) do_reset();
            for (int l = 0; l < vecs[i].n_lines; l++)
                run_line(vecs[i].len, vecs[i].hsw, 1'b0, -1, 1'b1);
            check("tbl_len", line_len, vecs[i].exp_len);
            check("tbl_ovf", overflow, vecs[i].exp_ovf);
            if (vecs[i].len <= HSYNC_W) check("short_hsync", hsync_31, 1'b0);
        end

        // Edge arrives while the read pointer sits on the last pixel.
        check("pre_edge_video", video_31, 9'd446);
        pixel(9'd0, 1'b0, vs_lvl);
        check("post_edge_video", video_31, 9'd0);
        check("post_edge_hsync", hsync_31, 1'b0);

        // vsync only follows at output line starts.
        do_reset();
        run_line(100, 10, 1'b0, -1, 1'b1);
        run_line(100, 10, 1'b0, -1, 1'b1);
        run_line(100, 10, 1'b0, 60, 1'b0);
        check("vs_not_before", vsync_31, 1'b1);
        pixel(9'd0, 1'b0, 1'b0);
        check("vs_fall", vsync_31, 1'b0);
        for (int p = 1; p < 100; p++) pixel(9'(p), (p < 10) ? 1'b0 : 1'b1, (p < 60) ? 1'b0 : 1'b1);
        check("vs_hold_low", vsync_31, 1'b0);
        vs_lvl = 1'b1;
        pixel(9'd0, 1'b0, 1'b1);
        check("vs_rise", vsync_31, 1'b1);
        for (int p = 1; p < 100; p++) pixel(9'(p), (p < 10) ? 1'b0 : 1'b1, 1'b1);

        // Randomized lines checked cycle-by-cycle against the model.
        do_reset();
        for (int l = 0; l < 10; l++) begin
            int len, hsw, vat;
            len = int'($urandom_range(20, 500));
            hsw = int'($urandom_range(1, (len < 80) ? len - 1 : 79));
            vat = int'($urandom_range(0, len - 1));
            run_line(len, hsw, 1'b1, vat, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scandoubler_linebuf.md
Name: scandoubler_linebuf

Overview:
- Upstream feeder of the VGA output selector: converts the 15 kHz RGB333 pixel stream into a 31 kHz stream by writing each input line into a ping-pong line buffer and reading it back twice at double pixel rate.
- Produces the video_31 / hsync / vsync set consumed by the scandouble output stage.
- Single clock domain with pixel-rate clock enables.

Parameters:
- ADDR_W, 10, line-buffer address width; maximum line length is 2^ADDR_W-1 pixels.
- HSYNC_W, 64, output hsync pulse width in ce_pix2 ticks.

Ports:
- clk_peripheral  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- ce_pix  in  1  input pixel strobe.
- ce_pix2  in  1  output pixel strobe at twice the ce_pix rate; must be high on every cycle where ce_pix is high.
- video_15  in  9  input pixel, RGB333 as {r[2:0], g[2:0], b[2:0]}.
- hsync_15  in  1  input hsync, active low.
- vsync_15  in  1  input vsync, active low.
- video_31  out  9  doubled-rate pixel, same RGB333 packing.
- hsync_31  out  1  output hsync, active low.
- vsync_31  out  1  output vsync, active low.
- line_len  out  ADDR_W  measured input line length in pixels.
- overflow  out  1  sticky flag: an input line exceeded 2^ADDR_W-1 pixels.

Behaviour:
- Reset (asynchronous, reset_n=0): video_31=0, hsync_31=1, vsync_31=1, line_len=0, overflow=0; wr_addr, rd_addr, banks and valid cleared. Line RAM contents are not cleared.
- Storage: two banks of 2^ADDR_W x 9 bits (inferred RAM).
- Write side, sampled only on ce_pix:
  - Write video_15 to bank wr_bank at wr_addr, then increment wr_addr.
  - wr_addr saturates at 2^ADDR_W-1. When saturated, further writes overwrite that address and overflow is set.
- Line edge: hsync_15 was 1 at the previous ce_pix sample and is 0 at this one. On the edge cycle:
  - line_len <= wr_addr.
  - rd_bank <= wr_bank; wr_bank toggles.
  - wr_addr <= 1; the edge pixel is written to address 0 of the new bank.
  - rd_addr <= 0.
  - valid_cnt increments, saturating at 2.
- Read side, on ce_pix2 when no edge occurs this cycle:
  - video_31 <= bank[rd_bank][rd_addr]; output latency is 1 clock after the ce_pix2 cycle.
  - rd_addr increments; it wraps to 0 when rd_addr == line_len-1.
  - Each stored line is therefore emitted twice per input line period.
- Edge coinciding with wrap or increment: the edge resync wins and rd_addr becomes 0.
- hsync_31: registered alongside video_31; equals 0 while rd_addr < HSYNC_W at the read, otherwise 1. If line_len <= HSYNC_W, hsync_31 stays low for the whole line; this is documented behaviour.
- vsync_31: loads the last sampled vsync_15 on each ce_pix2 read where rd_addr == 0. Output vsync is thus aligned to output line starts.
- Until valid_cnt == 2 (two edges seen since reset): video_31=0, hsync_31=1, vsync_31=1; counters still run.
- line_len == 0 after valid: rd_addr is held at 0 and video_31 repeats address 0.
- overflow is cleared only by reset.
- ce_pix2 without ce_pix is the normal case. ce_pix without ce_pix2 is illegal and the behaviour is undefined.

Test Plan:
- Reset: drive reset_n=0 mid-line with strobes active -> outputs immediately 0/1/1, line_len=0, overflow=0. Release -> video_31 stays 0 until two hsync_15 falling edges.
- Nominal line:
  - Stimulus: ce_pix every 4 clocks, ce_pix2 every 2 clocks, 448-pixel lines with video_15 = pixel index mod 512, hsync_15 low for 32 pixels.
  - Required: line_len=448. Each output line shows 0..447 twice per input line, 1 clock after ce_pix2. hsync_31 is low for the first 64 ce_pix2 reads of each half.
- Overflow: ADDR_W=10, 1100-pixel line -> overflow=1, line_len=1023; overflow stays 1 across subsequent 448-pixel lines.
- Resync collision: hsync_15 edge on the same cycle rd_addr == line_len-1 -> next read is address 0 of the new rd_bank, with no skipped or duplicated pixel.
- vsync: vsync_15=0 sampled mid-line -> vsync_31 goes 0 at the next rd_addr==0 read, not before. Return to 1 is handled the same way.
- Short line: 32-pixel lines with HSYNC_W=64 -> line_len=32, rd_addr wraps at 31, hsync_31 continuously 0.
